mult_pipe: RTL and testbench

//  Parametrised, pipelined fixed-point multiplier with valid/ready flow control,

---
 rtl/mult_pipe_if.sv | 28 ++
 rtl/mult_pipe.sv | 140 ++++++++++++++
 tb/tb_mult_pipe.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_pipe_if.sv
// Handshake and data bundle for the pipelined fixed-point multiplier.
// The slave side is the multiplier; the master side feeds operands and drains results.
`timescale 1ns/1ps
interface mult_pipe_if #(
    parameter int A_W   = 17,
    parameter int B_W   = 16,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   mult_in1;
    logic [B_W-1:0]   mult_in2;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] mult_out;
    logic             ovf;
    logic             ovf_clr;

    modport master (
        output in_valid, mult_in1, mult_in2, out_ready, ovf_clr,
        input  in_ready, out_valid, mult_out, ovf
    );

    modport slave (
        input  in_valid, mult_in1, mult_in2, out_ready, ovf_clr,
        output in_ready, out_valid, mult_out, ovf
    );
endinterface

// File: rtl/mult_pipe.sv
// Pipelined fixed-point multiplier: full product, optional round-half-up,
// right shift by SHIFT, clamp to OUT_W. Whole pipeline freezes on output stall.
// A sticky ovf flag records any clamped result.
`timescale 1ns/1ps
module mult_pipe #(
    parameter int A_W      = 17,
    parameter int B_W      = 16,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 16,
    parameter int A_SIGNED = 0,
    parameter int B_SIGNED = 1,
    parameter int ROUND    = 1,
    parameter int LAT      = 3
) (
    input logic       clk,
    input logic       rst,
    mult_pipe_if.slave bus
);
    // Internal width: exact product plus a guard bit for the rounding add and
    // a spare sign bit so unsigned-by-unsigned products stay positive.
    localparam int W = A_W + B_W + 2;
    localparam bit OUT_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
    localparam logic signed [W-1:0] ONE  = W'(1);
    localparam int                  RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [W-1:0] RND  = (ROUND != 0 && SHIFT > 0) ? (ONE <<< RSH) : '0;
    localparam logic signed [W-1:0] SMAX = OUT_SIGNED ? (ONE <<< (OUT_W - 1)) - ONE
                                                      : (ONE <<< OUT_W) - ONE;
    localparam logic signed [W-1:0] SMIN = OUT_SIGNED ? -(ONE <<< (OUT_W - 1)) : '0;

    function automatic logic signed [W-1:0] f_mul(input logic [A_W-1:0] a,
                                                  input logic [B_W-1:0] b);
        logic signed [W-1:0] ax;
        logic signed [W-1:0] bx;
        ax = {{(W-A_W){(A_SIGNED != 0) & a[A_W-1]}}, a};
        bx = {{(W-B_W){(B_SIGNED != 0) & b[B_W-1]}}, b};
        return ax * bx;
    endfunction

    function automatic logic signed [W-1:0] f_rsh(input logic signed [W-1:0] p);
        return (p + RND) >>> SHIFT;
    endfunction

    function automatic logic f_ovf(input logic signed [W-1:0] s);
        return (s > SMAX) || (s < SMIN);
    endfunction

    function automatic logic [OUT_W-1:0] f_sat(input logic signed [W-1:0] s);
        if (s > SMAX) return SMAX[OUT_W-1:0];
        if (s < SMIN) return SMIN[OUT_W-1:0];
        return s[OUT_W-1:0];
    endfunction

    logic                w_stall;
    logic                w_en;
    logic signed [W-1:0] w_last_s;
    logic                w_last_v;
    logic                r_vld_p2;
    logic [OUT_W-1:0]    r_out_p2;
    logic                r_ovf;

    assign w_stall      = r_vld_p2 && !bus.out_ready;
    assign w_en         = !w_stall;
    assign bus.in_ready = w_en;
    assign bus.out_valid = r_vld_p2;
    assign bus.mult_out = r_out_p2;
    assign bus.ovf      = r_ovf;

    if (LAT < 1 || LAT > 6) begin : g_lat_chk
        $error("mult_pipe: LAT=%0d is outside 1..6", LAT);
    end

    if (LAT == 1) begin : g_lat1
        // Single-register build: the whole datapath is combinational into the output register.
        assign w_last_s = f_rsh(f_mul(bus.mult_in1, bus.mult_in2));
        assign w_last_v = bus.in_valid;
    end else begin : g_latn
        logic signed [W-1:0] r_prod_p0;
        logic                r_vld_p0;

        // Stage 0: full-precision product.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_vld_p0  <= 1'b0;
                r_prod_p0 <= '0;
            end else if (w_en) begin
                r_vld_p0 <= bus.in_valid;
                if (bus.in_valid) r_prod_p0 <= f_mul(bus.mult_in1, bus.mult_in2);
            end
        end

        if (LAT == 2) begin : g_lat2
            assign w_last_s = f_rsh(r_prod_p0);
            assign w_last_v = r_vld_p0;
        end else begin : g_lat3p
            localparam int NM = LAT - 2;
            logic signed [W-1:0] r_scl_p1 [NM];
            logic [NM-1:0]       r_vld_p1;

            // Stage 1: round and shift, then any extra delay stages carry the scaled value.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vld_p1 <= '0;
                    for (int k = 0; k < NM; k++) r_scl_p1[k] <= '0;
                end else if (w_en) begin
                    r_vld_p1[0] <= r_vld_p0;
                    if (r_vld_p0) r_scl_p1[0] <= f_rsh(r_prod_p0);
                    for (int k = 1; k < NM; k++) begin
                        r_vld_p1[k] <= r_vld_p1[k-1];
                        if (r_vld_p1[k-1]) r_scl_p1[k] <= r_scl_p1[k-1];
                    end
                end
            end

            assign w_last_s = r_scl_p1[NM-1];
            assign w_last_v = r_vld_p1[NM-1];
        end
    end

    // Stage 2: saturate into the output register; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p2 <= 1'b0;
            r_out_p2 <= '0;
        end else if (w_en) begin
            r_vld_p2 <= w_last_v;
            if (w_last_v) r_out_p2 <= f_sat(w_last_s);
        end
    end

    // Sticky overflow: a saturating load wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_en && w_last_v && f_ovf(w_last_s)) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: five builds (default, truncating, LAT=1, LAT=6,
// signed-A/unsigned-B) share one stimulus stream and are checked side by side.
`timescale 1ns/1ps
module tb_mult_pipe;
    localparam int N = 5;
    localparam int LATS [N] = '{3, 3, 1, 6, 3};
    localparam int RNDS [N] = '{1, 0, 1, 1, 1};
    localparam int ASG  [N] = '{0, 0, 0, 0, 1};
    localparam int BSG  [N] = '{1, 1, 1, 1, 0};
    localparam logic [16:0] TA [10] = '{17'h10000, 17'h08000, 17'h1FFFF, 17'h00001, 17'h12345,
                                        17'h0ABCD, 17'h18000, 17'h00100, 17'h1F000, 17'h05555};
    localparam logic [15:0] TB [10] = '{16'h4000, 16'hC000, 16'h7FFF, 16'h8000, 16'h1234,
                                        16'hFEDC, 16'h0001, 16'h7000, 16'h8001, 16'hAAAA};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        ovf_clr = 1'b0;
    logic [16:0] a = '0;
    logic [15:0] b = '0;
    wire [N-1:0] ov;
    wire [N-1:0] ovf;
    wire [N-1:0] ir;
    wire [15:0]  mo [N];
    wire         all_rdy;
    int          total = 0;
    int          bad = 0;

    assign all_rdy = &ir;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mult_pipe_if #(.A_W(17), .B_W(16), .OUT_W(16)) bus ();
        mult_pipe #(.A_W(17), .B_W(16), .OUT_W(16), .SHIFT(16), .A_SIGNED(ASG[g]),
                    .B_SIGNED(BSG[g]), .ROUND(RNDS[g]), .LAT(LATS[g]))
            u_dut (.clk(clk), .rst(rst), .bus(bus));
        assign bus.in_valid  = in_valid & all_rdy;
        assign bus.mult_in1  = a;
        assign bus.mult_in2  = b;
        assign bus.out_ready = out_ready;
        assign bus.ovf_clr   = ovf_clr;
        assign ov[g]  = bus.out_valid;
        assign ovf[g] = bus.ovf;
        assign ir[g]  = bus.in_ready;
        assign mo[g]  = bus.mult_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] model(input int i, input logic [16:0] x, input logic [15:0] y);
        longint av, bv, p, s, mx, mn;
        av = (ASG[i] != 0) ? longint'($signed(x)) : longint'(x);
        bv = (BSG[i] != 0) ? longint'($signed(y)) : longint'(y);
        p = av * bv;
        if (RNDS[i] != 0) p = p + 32768;
        s = p >>> 16;
        if (ASG[i] != 0 || BSG[i] != 0) begin mx = 32767; mn = -32768; end
        else begin mx = 65535; mn = 0; end
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        return s[15:0];
    endfunction

    // One operand, then cycle-by-cycle check of every build's valid/data/ovf.
    task automatic single(input string nm, input logic [16:0] x, input logic [15:0] y,
                          input logic [N*16-1:0] e, input logic [N-1:0] eo, input logic clr);
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y; ovf_clr = clr;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            for (int i = 0; i < N; i++) begin
                chk($sformatf("%s valid d%0d k%0d", nm, i, k), 32'(ov[i]), 32'(k == LATS[i]));
                if (k == LATS[i]) begin
                    chk($sformatf("%s data d%0d", nm, i), 32'(mo[i]), 32'(e[i*16 +: 16]));
                    chk($sformatf("%s ovf d%0d", nm, i), 32'(ovf[i]), 32'(eo[i]));
                end
                if (clr && k == LATS[i] + 1)
                    chk($sformatf("%s ovf cleared d%0d", nm, i), 32'(ovf[i]), 32'(0));
            end
            @(negedge clk);
        end
        ovf_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          rc [N];
        logic [15:0] hold_mo [N];
        logic [N-1:0] hold_ov;
        bit          done;

        // Reset state
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset valid d%0d", i), 32'(ov[i]), 32'(0));
            chk($sformatf("reset data d%0d", i), 32'(mo[i]), 32'(0));
            chk($sformatf("reset ovf d%0d", i), 32'(ovf[i]), 32'(0));
            chk($sformatf("reset ready d%0d", i), 32'(ir[i]), 32'(1));
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed single operands (d4 order first in each concatenation)
        single("t1 1.0x0.5", 17'h10000, 16'h4000,
               {16'hC000, 16'h4000, 16'h4000, 16'h4000, 16'h4000}, 5'b00000, 1'b0);
        single("t3 exact min", 17'h10000, 16'h8000,
               {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000}, 5'b00000, 1'b0);
        single("t4 round", 17'h00001, 16'h8000,
               {16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000}, 5'b00000, 1'b0);
        single("t2 saturate", 17'h1FFFF, 16'h7FFF,
               {16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 5'b01111, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("t2 ovf sticky d%0d", i), 32'(ovf[i]), 32'(i != 4));
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("t2 ovf clr d%0d", i), 32'(ovf[i]), 32'(0));
        single("t2 set+clr", 17'h1FFFF, 16'h7FFF,
               {16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 5'b01111, 1'b1);

        // Stream of 10 with a 4-cycle output hold
        idx = 0;
        done = 1'b0;
        for (int i = 0; i < N; i++) rc[i] = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            out_ready = !(c >= 8 && c < 12);
            in_valid  = (idx < 10);
            a = TA[(idx < 10) ? idx : 9];
            b = TB[(idx < 10) ? idx : 9];
            #1;
            if (c == 8) begin
                hold_ov = ov;
                for (int i = 0; i < N; i++) hold_mo[i] = mo[i];
            end
            for (int i = 0; i < N; i++) begin
                if (c >= 8 && c < 12)
                    chk($sformatf("t5 in_ready hold d%0d c%0d", i, c), 32'(ir[i]), 32'(0));
                if (c > 8 && c <= 12) begin
                    chk($sformatf("t5 valid stable d%0d c%0d", i, c), 32'(ov[i]), 32'(hold_ov[i]));
                    chk($sformatf("t5 data stable d%0d c%0d", i, c), 32'(mo[i]), 32'(hold_mo[i]));
                end
                if (ov[i] && out_ready) begin
                    if (rc[i] < 10)
                        chk($sformatf("t5 result d%0d n%0d", i, rc[i]), 32'(mo[i]),
                            32'(model(i, TA[rc[i]], TB[rc[i]])));
                    else
                        chk($sformatf("t5 extra result d%0d", i), 32'(rc[i] + 1), 32'(10));
                    rc[i]++;
                end
            end
            if (in_valid && all_rdy) idx++;
            done = (idx == 10);
            for (int i = 0; i < N; i++) if (rc[i] != 10) done = 1'b0;
        end
        in_valid = 1'b0;
        for (int i = 0; i < N; i++)
            chk($sformatf("t5 result count d%0d", i), 32'(rc[i]), 32'(10));
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("t5 no duplicate d%0d", i), 32'(ov[i]), 32'(0));

        // Reset with results in flight
        @(negedge clk);
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            a = (j == 0) ? 17'h1FFFF : TA[j];
            b = (j == 0) ? 16'h7FFF : TB[j];
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("t6 in flight valid d0", 32'(ov[0]), 32'(1));
        chk("t6 in flight data d0", 32'(mo[0]), 32'h7FFF);
        chk("t6 in flight ovf d0", 32'(ovf[0]), 32'(1));
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("t6 reset valid d%0d", i), 32'(ov[i]), 32'(0));
            chk($sformatf("t6 reset data d%0d", i), 32'(mo[i]), 32'(0));
            chk($sformatf("t6 reset ovf d%0d", i), 32'(ovf[i]), 32'(0));
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++)
                chk($sformatf("t6 no stale d%0d c%0d", i, c), 32'(ov[i]), 32'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
